// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential restoring divider.
//   state_t    : FSM state encoding (IDLE=00, EXEC=01, DONE=10, 11 illegal)
//   CNT_W      : iteration counter width for the default 32-bit divider
//   cnt_w_of() : counter width for an arbitrary operand width
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Counter must hold WIDTH-1; clog2(WIDTH) bits always suffice.
  function automatic int cnt_w_of(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_seq_cla_sub.sv
// cla_sub -- (WIDTH+1)-bit subtractor diff = a - b, computed as a + ~b + 1.
//   a, b   : WIDTH+1 bit operands
//   diff   : WIDTH+1 bit difference
//   borrow : 1 when a < b (inverted carry-out)
// The low WIDTH bits are covered by chained 4-bit carry-lookahead groups;
// the extra top bit is a single ripple stage.
module cla_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH:0] p;
  logic [WIDTH:0] g;

  assign p = a ^ ~b;
  assign g = a & ~b;

  always_comb begin
    logic       carry;
    logic [3:0] p4;
    logic [3:0] g4;
    logic       c1, c2, c3, c4;
    carry = 1'b1;
    diff  = '0;
    p4    = '0;
    g4    = '0;
    c1    = 1'b0;
    c2    = 1'b0;
    c3    = 1'b0;
    c4    = 1'b0;
    for (int k = 0; k < WIDTH / 4; k++) begin
      p4 = p[4*k +: 4];
      g4 = g[4*k +: 4];
      // Every carry inside a group is formed from the group carry-in only.
      c1 = g4[0] | (p4[0] & carry);
      c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & carry);
      c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & carry);
      c4 = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0])
         | (p4[3] & p4[2] & p4[1] & p4[0] & carry);
      diff[4*k +: 4] = p4 ^ {c3, c2, c1, carry};
      carry = c4;
    end
    diff[WIDTH] = p[WIDTH] ^ carry;
    borrow      = ~(g[WIDTH] | (p[WIDTH] & carry));
  end

endmodule

// File: rtl/div_seq.sv
// div_seq -- multi-cycle unsigned restoring divider, one quotient bit/clock.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request a division (accepted in IDLE or DONE)
//   clear       : DONE -> IDLE
//   dividend    : numerator, latched on accepted start
//   divisor     : denominator, latched on accepted start
//   quotient    : result quotient (valid while done)
//   remainder   : result remainder (valid while done)
//   busy        : high in EXEC
//   done        : high in DONE
//   div_by_zero : high in DONE when the latched divisor was zero
// Handshake: start is a request sampled only in IDLE/DONE; the result is
// held with done=1 until clear or a new start is accepted.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_w_of(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    count;
  logic             dz_reg;

  logic             accept;
  logic             zero_div;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t_diff;
  logic             t_borrow;
  logic             unused_r_msb;

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign zero_div = (divisor == '0);

  // Shift {R,Q} left by one. R[WIDTH] is always 0 after a restoring step
  // (R < D), so dropping it loses nothing.
  assign r_sh         = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign q_sh         = {q_reg[WIDTH-2:0], 1'b0};
  assign unused_r_msb = r_reg[WIDTH];

  cla_sub #(.WIDTH(WIDTH)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, d_reg}),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = zero_div ? S_DONE : S_EXEC;
      S_EXEC: if (count == '0) state_nx = S_DONE;
      S_DONE: begin
        if (start)      state_nx = zero_div ? S_DONE : S_EXEC;
        else if (clear) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg  <= '0;
      r_reg  <= '0;
      d_reg  <= '0;
      count  <= '0;
      dz_reg <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        q_reg  <= '1;
        r_reg  <= {1'b0, dividend};
        d_reg  <= '0;
        count  <= '0;
        dz_reg <= 1'b1;
      end else begin
        q_reg  <= dividend;
        r_reg  <= '0;
        d_reg  <= divisor;
        count  <= CW'(WIDTH - 1);
        dz_reg <= 1'b0;
      end
    end else if (state == S_EXEC) begin
      // Restoring step: keep the shifted remainder when the trial borrows.
      r_reg <= t_borrow ? r_sh : t_diff;
      q_reg <= {q_sh[WIDTH-1:1], ~t_borrow};
      if (count != '0) count <= count - 1'b1;
    end else if ((state == S_DONE) && clear) begin
      dz_reg <= 1'b0;
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg[WIDTH-1:0];
  assign busy        = (state == S_EXEC);
  assign done        = (state == S_DONE);
  assign div_by_zero = (state == S_DONE) && dz_reg;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq -- directed self-checking bench for div_seq (WIDTH=32).
module tb_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         clear;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clear       (clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs and samples are taken 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Start an operation now (cycle 0) and run until done or 100 cycles.
  // lat = cycle index where done was first seen; busy_bad = EXEC cycles
  // before done where busy was low.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_bad);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    busy_bad = 0;
    tick();
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; clear = 1'b0;
    dividend = 32'd5; divisor = 32'd0;
    tick();
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_wins_done got=%b exp=0", done); end
    start = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero}); end
  endtask

  task automatic test_basic();
    int lat, bb;
    run_op(32'd100, 32'd7, lat, bb);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL basic_busy_low_cycles got=%0d exp=0", bb); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_clear_done got=%b exp=0", done); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_clear_keeps_q got=%0d exp=14", quotient); end
  endtask

  task automatic test_max_dividend();
    int lat, bb;
    run_op(32'hFFFF_FFFF, 32'd1, lat, bb);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL max_latency got=%0d exp=33", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_quotient got=%h exp=ffffffff", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL max_remainder got=%h exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL max_dbz got=%b exp=0", div_by_zero); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat, bb;
    run_op(32'd5, 32'd0, lat, bb);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quotient got=%h exp=ffffffff", quotient); end
    n_checks++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL dz_remainder got=%0d exp=5", remainder); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if ({done, div_by_zero} !== 2'b00) begin n_fail++; $display("FAIL dz_clear got=%b exp=00", {done, div_by_zero}); end
  endtask

  task automatic test_small_and_equal();
    int lat, bb;
    run_op(32'd3, 32'd10, lat, bb);
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL small_quotient got=%0d exp=0", quotient); end
    n_checks++; if (remainder !== 32'd3) begin n_fail++; $display("FAIL small_remainder got=%0d exp=3", remainder); end
    clear = 1'b1; tick(); clear = 1'b0;
    run_op(32'h8000_0000, 32'h8000_0000, lat, bb);
    n_checks++; if (quotient !== 32'd1) begin n_fail++; $display("FAIL equal_quotient got=%0d exp=1", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL equal_remainder got=%0d exp=0", remainder); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // start/clear and new operands mid-EXEC must be ignored: 1000/9 = 111 r 1.
  task automatic test_ignore_start();
    int cyc;
    dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 10) begin
        start = 1'b1; clear = 1'b1; dividend = 32'd5; divisor = 32'd0;
      end else begin
        start = 1'b0; clear = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0; clear = 1'b0;
    n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=33", cyc); end
    n_checks++; if (quotient !== 32'd111) begin n_fail++; $display("FAIL ignore_quotient got=%0d exp=111", quotient); end
    n_checks++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL ignore_remainder got=%0d exp=1", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ignore_dbz got=%b exp=0", div_by_zero); end
  endtask

  // Left in DONE by the previous test: start again without clear.
  task automatic test_back_to_back();
    int lat, bb;
    run_op(32'd50, 32'd6, lat, bb);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL b2b_busy_low_cycles got=%0d exp=0", bb); end
    n_checks++; if (quotient !== 32'd8) begin n_fail++; $display("FAIL b2b_quotient got=%0d exp=8", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL b2b_remainder got=%0d exp=2", remainder); end
    // Divide-by-zero accepted straight from DONE as well.
    run_op(32'd77, 32'd0, lat, bb);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_dz_latency got=%0d exp=1", lat); end
    n_checks++; if (remainder !== 32'd77) begin n_fail++; $display("FAIL b2b_dz_remainder got=%0d exp=77", remainder); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat, bb;
    dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL midop_flags got=%b exp=000", {busy, done, div_by_zero}); end
    n_checks++; if ({quotient, remainder} !== 64'd0) begin n_fail++; $display("FAIL midop_outputs got=%h exp=0", {quotient, remainder}); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midop_no_done got=%b exp=0", done); end
    run_op(32'd9, 32'd3, lat, bb);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL midop_new_latency got=%0d exp=33", lat); end
    n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL midop_new_quotient got=%0d exp=3", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL midop_new_remainder got=%0d exp=0", remainder); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_max_dividend();
    test_div_zero();
    test_small_and_equal();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle unsigned restoring divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient and remainder.
- Produces one quotient bit per clock. The trial subtraction runs on a carry-lookahead subtractor built from the team's 4-bit carry-lookahead block.
- Complements the CLA adder datapath: adders compose upward, this block decomposes (division).
- Sits beside the ALU/multiplier as a start/done slave of the execution controller.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE or DONE
- clear  input  1  return DONE -> IDLE; ignored in other states
- dividend  input  WIDTH  numerator; sampled on accepted start
- divisor  input  WIDTH  denominator; sampled on accepted start
- quotient  output  WIDTH  result quotient; valid while done=1
- remainder  output  WIDTH  result remainder; valid while done=1
- busy  output  1  high in EXEC
- done  output  1  high in DONE
- div_by_zero  output  1  high in DONE when the latched divisor was 0

Behaviour:
- Interface (already decided): one clock, clk. Reset port reset is synchronous and active-high.
- Reset: state=IDLE; quotient, remainder, busy, done, div_by_zero, count and internal registers all 0. Reset wins over start and clear in the same cycle. Reset mid-EXEC aborts the operation; no done is produced.
- State encoding and transitions:
  - IDLE (00):
    - start=1 and divisor!=0: load Q=dividend, R=0 (WIDTH+1 bits), D=divisor, count=WIDTH-1; go to EXEC.
    - start=1 and divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1; go to DONE.
  - EXEC (01), each cycle:
    - {R,Q} shifted left by 1.
    - T = R_shifted - {0,D}.
    - If T has no borrow: R=T, Q[0]=1. Otherwise R unchanged, Q[0]=0.
    - When count==0, go to DONE; otherwise count decrements.
    - start and clear are ignored.
  - DONE (10):
    - Holds quotient=Q and remainder=R[WIDTH-1:0].
    - clear=1: go to IDLE; done and div_by_zero drop the next cycle. quotient and remainder keep their values.
    - start=1 (takes priority over clear): accepted exactly as in IDLE.
  - 11: illegal; recovers to IDLE on the next clock.
- Latency: start is high in cycle 0.
  - Nonzero divisor: EXEC occupies cycles 1..WIDTH; done=1 from cycle WIDTH+1.
  - Zero divisor: done=1 from cycle 1.
- Arithmetic: R is WIDTH+1 bits wide so the shifted remainder never overflows.
  - Result satisfies dividend = quotient*divisor + remainder and remainder < divisor.
- Operands are latched at start; input changes during EXEC have no effect.

Decomposition:
- Shared package div_pkg holds:
  - State encoding constants S_IDLE=2'b00, S_EXEC=2'b01, S_DONE=2'b10.
  - Counter width constant CNT_W = clog2(WIDTH).
- One sub-module, cla_sub:
  - (WIDTH+1)-bit subtractor: a + ~b with carry-in 1.
  - Built by chaining 4-bit carry-lookahead blocks; the top bit is ripple.
  - Outputs difference and borrow (= ~carry-out).
- The FSM, shift registers and counter stay in div_seq.

Test Plan:
- Basic division, WIDTH=32: dividend=100, divisor=7 -> quotient=14, remainder=2, done rises cycle 33, busy high cycles 1..32.
- Maximum dividend: 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0, div_by_zero=0.
- Divide by zero: 5 / 0 -> done at cycle 1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5; clear -> done=0 and div_by_zero=0 next cycle.
- Dividend smaller than divisor: 3 / 10 -> quotient=0, remainder=3. Equal operands: 0x80000000 / 0x80000000 -> quotient=1, remainder=0.
- Protocol:
  - start and changed operands pulsed at cycle 10 of EXEC -> ignored; the original result is produced.
  - start held high in DONE -> back-to-back operation accepted.
- Reset mid-op: reset at cycle 15 of EXEC -> next cycle all outputs 0 and state IDLE; a new start (9/3) then gives quotient=3, remainder=0.
